// File: rtl/prefetch_fifo_pkg.sv
// Shared definitions for the prefetch FIFO read/write schedulers.
// Holds the arbiter state encoding and the width helper.
package prefetch_fifo_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Like $clog2, but never returns less than 1.
    function automatic int clog2_min1(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/prefetch_fifo_rd_arbiter_if.sv
// Read-side bundle: FIFO read ports on one side, the merged
// output stream on the other.
interface prefetch_fifo_rd_arbiter_if #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 8
);
    localparam int SEL_W = prefetch_fifo_pkg::clog2_min1(N_SRC);

    logic [N_SRC-1:0]        src_mask;
    logic [N_SRC-1:0]        src_vld;
    logic [N_SRC*DATA_W-1:0] src_data;
    logic [N_SRC-1:0]        src_rd_en;
    logic                    out_vld;
    logic [DATA_W-1:0]       out_data;
    logic [SEL_W-1:0]        out_src;
    logic                    out_last;
    logic                    out_rdy;
    logic                    busy;

    modport master (
        input  src_mask, src_vld, src_data, out_rdy,
        output src_rd_en, out_vld, out_data, out_src, out_last, busy
    );

    modport slave (
        output src_mask, src_vld, src_data, out_rdy,
        input  src_rd_en, out_vld, out_data, out_src, out_last, busy
    );

endinterface

// File: rtl/prefetch_rr_pick.sv
// Rotate-priority encoder: first set request at or after rr_ptr,
// wrapping modulo N_SRC.
module prefetch_rr_pick
    import prefetch_fifo_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int SEL_W = clog2_min1(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] rr_ptr,
    output logic [SEL_W-1:0] pick,
    output logic             any
);

    logic [2*N_SRC-1:0] dbl;
    logic [N_SRC-1:0]   rot;

    // rot[i] is the request i positions after rr_ptr
    assign dbl = {req, req} >> rr_ptr;
    assign rot = dbl[N_SRC-1:0];

    always_comb begin
        logic [SEL_W:0] sum;
        pick = '0;
        any  = 1'b0;
        sum  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum = {1'b0, rr_ptr} + (SEL_W+1)'(i);
                if (sum >= (SEL_W+1)'(N_SRC))
                    sum = sum - (SEL_W+1)'(N_SRC);
                pick = sum[SEL_W-1:0];
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prefetch_fifo_rd_arbiter.sv
// Burst round-robin read scheduler sharing one consumer
// between N_SRC prefetch FIFOs.
module prefetch_fifo_rd_arbiter
    import prefetch_fifo_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 16
) (
    input  logic rd_clk,
    input  logic rd_rst,
    prefetch_fifo_rd_arbiter_if.master bus
);

    localparam int SEL_W = clog2_min1(N_SRC);
    localparam int CNT_W = clog2_min1(BURST_LEN);

    logic [1:0]        rst_sync;
    logic              core_rst;
    arb_state_t        state;
    logic [SEL_W-1:0]  grant;
    logic [SEL_W-1:0]  rr_ptr;
    logic [SEL_W-1:0]  nxt_ptr;
    logic [SEL_W-1:0]  pick;
    logic [CNT_W-1:0]  beat_cnt;
    logic [N_SRC-1:0]  req;
    logic [N_SRC-1:0]  rd_en;
    logic              any;
    logic              in_grant;
    logic              vld_g;
    logic              pop;
    logic              last;
    logic [DATA_W-1:0] data_arr [N_SRC];

    // Assert immediately, release two rd_clk edges later.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) rst_sync <= 2'b11;
        else        rst_sync <= {rst_sync[0], 1'b0};
    end

    assign core_rst = rst_sync[1];

    for (genvar i = 0; i < N_SRC; i++) begin : g_data
        assign data_arr[i] = bus.src_data[i*DATA_W +: DATA_W];
    end

    assign req      = bus.src_vld & bus.src_mask;
    assign in_grant = (state == ST_GRANT);
    assign vld_g    = bus.src_vld[grant];
    assign pop      = bus.out_vld & bus.out_rdy;
    assign last     = (beat_cnt == CNT_W'(BURST_LEN - 1));
    assign nxt_ptr  = (grant == SEL_W'(N_SRC - 1)) ? '0
                    : grant + SEL_W'(1);

    prefetch_rr_pick #(
        .N_SRC (N_SRC),
        .SEL_W (SEL_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .pick   (pick),
        .any    (any)
    );

    always_ff @(posedge rd_clk or posedge core_rst) begin
        if (core_rst) begin
            state    <= ST_IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    beat_cnt <= '0;
                    if (any) begin
                        grant <= pick;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!vld_g) begin
                        state  <= ST_IDLE;
                        rr_ptr <= nxt_ptr;
                    end else if (pop) begin
                        if (last) begin
                            state  <= ST_IDLE;
                            rr_ptr <= nxt_ptr;
                        end
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_en = '0;
        if (in_grant && bus.out_rdy && vld_g)
            rd_en[grant] = 1'b1;
    end

    assign bus.src_rd_en = rd_en;
    assign bus.out_vld   = in_grant & vld_g;
    assign bus.out_data  = in_grant ? data_arr[grant] : '0;
    assign bus.out_src   = grant;
    assign bus.out_last  = bus.out_vld & last;
    assign bus.busy      = in_grant;

endmodule
